// File: rtl/gobou_img_fetch_if.sv
// rtl/gobou_img_fetch_if.sv - image memory read port and output word stream of gobou_img_fetch
`include "gobou.vh"
interface gobou_img_fetch_if;
  logic        [IMGSIZE-1:0] mem_addr;
  logic signed [DWIDTH-1:0]  read_data;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [DWIDTH-1:0]  out_data;
  logic                      out_last;

  modport master (
    output mem_addr,
    input  read_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  mem_addr,
    output read_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );
endinterface

// File: rtl/gobou.vh
// rtl/gobou.vh - shared gobou datapath widths
`ifndef GOBOU_VH
`define GOBOU_VH
localparam int DWIDTH  = 16;
localparam int IMGSIZE = 4;
`endif

// File: rtl/gobou_img_fetch.sv
// rtl/gobou_img_fetch.sv - burst reader: image memory -> 2-entry FIFO -> valid/ready stream
// Optional macro GOBOU_IMG_FETCH_STALL_CNT_EN adds the stall_cnt output.
`include "gobou.vh"
module gobou_img_fetch (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IMGSIZE-1:0] base,
  input  logic [IMGSIZE:0]   len,
  output logic               busy,
  output logic               done,
`ifdef GOBOU_IMG_FETCH_STALL_CNT_EN
  output logic [31:0]        stall_cnt,
`endif
  gobou_img_fetch_if.master  bus
);

  localparam logic [IMGSIZE:0] LEN_ZERO = '0;
  localparam logic [IMGSIZE:0] LEN_ONE  = {{IMGSIZE{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic        [IMGSIZE:0]   rem;
  logic                      fl_valid;
  logic                      fl_last;
  logic signed [DWIDTH-1:0]  fifo_data [2];
  logic                      fifo_last [2];
  logic                      rd_ptr;
  logic                      wr_ptr;
  logic        [1:0]         cnt;
  logic        [1:0]         occ_after;
  logic                      pop;
  logic                      issue;
  logic                      issue_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && len != LEN_ZERO) state_nxt = RUN;
      RUN:     if (rem == LEN_ZERO || (issue && issue_last)) state_nxt = DRAIN;
      DRAIN:   if (pop && bus.out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // occ_after is the FIFO fill once this edge's capture and pop land; a new
  // issue is allowed only if that plus the new in-flight word fits in two slots.
  always_comb begin
    busy          = (state != IDLE);
    bus.out_valid = (cnt != 2'd0);
    bus.out_data  = fifo_data[rd_ptr];
    bus.out_last  = fifo_last[rd_ptr] && (cnt != 2'd0);
    pop           = (cnt != 2'd0) && bus.out_ready;
    occ_after     = cnt + {1'b0, fl_valid} - {1'b0, pop};
    issue         = 1'b0;
    issue_last    = 1'b0;
    if (state == IDLE && start && len != LEN_ZERO) begin
      issue      = 1'b1;
      issue_last = (len == LEN_ONE);
    end else if (state == RUN && rem != LEN_ZERO && occ_after < 2'd2) begin
      issue      = 1'b1;
      issue_last = (rem == LEN_ONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_addr <= '0;
      rem          <= '0;
      fl_valid     <= 1'b0;
      fl_last      <= 1'b0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      cnt          <= 2'd0;
      done         <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      done     <= (state == IDLE && start && len == LEN_ZERO) || (pop && bus.out_last);
      fl_valid <= issue;
      fl_last  <= issue && issue_last;
      if (issue) begin
        if (state == IDLE) begin
          bus.mem_addr <= base;
          rem          <= len - LEN_ONE;
        end else begin
          bus.mem_addr <= bus.mem_addr + 1'b1;
          rem          <= rem - LEN_ONE;
        end
      end
      if (fl_valid) begin
        fifo_data[wr_ptr] <= bus.read_data;
        fifo_last[wr_ptr] <= fl_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= occ_after;
    end
  end

`ifdef GOBOU_IMG_FETCH_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (state == IDLE && start)
      stall_cnt <= '0;
    else if (bus.out_valid && !bus.out_ready && stall_cnt != '1)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_gobou_img_fetch.sv
// tb/tb_gobou_img_fetch.sv - scoreboard bench for gobou_img_fetch
module tb_gobou_img_fetch;
  localparam int TB_DW = 16;
  localparam int TB_IS = 4;
  localparam int TB_MEM = 1 << TB_IS;

  typedef struct {
    int data;
    bit last;
    int cyc;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               start;
  logic [TB_IS-1:0]   base;
  logic [TB_IS:0]     len;
  logic               busy;
  logic               done;
`ifdef GOBOU_IMG_FETCH_STALL_CNT_EN
  logic [31:0]        stall_cnt;
`endif

  gobou_img_fetch_if bus();

  gobou_img_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base      (base),
    .len       (len),
    .busy      (busy),
    .done      (done),
`ifdef GOBOU_IMG_FETCH_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .bus       (bus)
  );

  logic signed [TB_DW-1:0] mem [TB_MEM];
  assign bus.read_data = mem[bus.mem_addr];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   xfer_cnt = 0;
  int   stalls = 0;
  bit   toggle = 0;
  bit   ready_lvl = 1;
  int   pat [4] = '{1, 0, 0, 1};
  exp_t exp_q [$];

  task automatic chk(input string nm, input longint act, input longint req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int ph = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (toggle) begin
        bus.out_ready = pat[ph][0];
        ph = (ph + 1) % 4;
      end else begin
        bus.out_ready = ready_lvl;
        ph = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake, checks hold-stability on stalls.
  initial begin
    bit   held = 0;
    int   hd = 0;
    bit   hl = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0;
      end else if (bus.out_valid) begin
        if (held) begin
          chk("stall_data_stable", bus.out_data, hd);
          chk("stall_last_stable", bus.out_last, hl);
        end
        if (bus.out_ready) begin
          xfer_cnt++;
          held = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_word", bus.out_data, -1);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", bus.out_data, e.data);
            chk("out_last", bus.out_last, e.last);
            if (e.cyc >= 0) chk("out_cycle", cyc, e.cyc);
          end
        end else begin
          held = 1;
          hd = bus.out_data;
          hl = bus.out_last;
          stalls++;
        end
      end else begin
        held = 0;
      end
    end
  end

  task automatic start_burst(input int b, input int l, input bit timed, output int k0);
    exp_t e;
    start = 1'b1;
    base  = b[TB_IS-1:0];
    len   = l[TB_IS:0];
    @(posedge clk);
    #1;
    k0 = cyc;
    start = 1'b0;
    for (int i = 0; i < l; i++) begin
      e.data = (b + i) % TB_MEM;
      e.last = (i == l - 1);
      e.cyc  = timed ? k0 + 1 + i : -1;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input int req_cyc, input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < bound);
    chk("done_seen", done, 1);
    if (req_cyc >= 0) chk("done_cycle", cyc, req_cyc);
    chk("busy_at_done", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int k0;
    int k1;
    int x0;
    int n;
    for (int i = 0; i < TB_MEM; i++) mem[i] = i[TB_DW-1:0];
    rst = 1'b1;
    start = 1'b0;
    base = '0;
    len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_out_data", bus.out_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // basic burst, first word one cycle after the accepting edge
    start_burst(5, 4, 1, k0);
    @(negedge clk);
    chk("busy_in_burst", busy, 1);
    wait_done(k0 + 5, 40);

    // wrap across the top of the address space
    @(posedge clk);
    #1;
    start_burst(TB_MEM - 2, 4, 1, k0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wrap_mem_addr", bus.mem_addr, (TB_MEM - 2 + i) % TB_MEM);
    end
    wait_done(k0 + 5, 40);
    chk("mem_addr_hold", bus.mem_addr, 1);

    // downstream stalls with out_ready pattern 1,0,0,1
    @(posedge clk);
    #1;
    toggle = 1;
    stalls = 0;
    start_burst(3, 8, 0, k0);
    wait_done(-1, 200);
    toggle = 0;
`ifdef GOBOU_IMG_FETCH_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, stalls);
`endif

    // zero-length request
    @(posedge clk);
    #1;
    start_burst(4, 0, 1, k0);
    wait_done(k0, 5);
    @(negedge clk);
    chk("len0_done_pulse", done, 0);
    chk("len0_mem_addr", bus.mem_addr, 10);

    // single word and full address space
    @(posedge clk);
    #1;
    start_burst(3, 1, 1, k0);
    wait_done(k0 + 2, 20);
    @(posedge clk);
    #1;
    start_burst(7, TB_MEM, 1, k0);
    wait_done(k0 + TB_MEM + 1, 100);

    // reset after three of six words
    @(posedge clk);
    #1;
    x0 = xfer_cnt;
    start_burst(9, 6, 1, k0);
    n = 0;
    while (xfer_cnt < x0 + 3 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("three_words_before_rst", xfer_cnt - x0, 3);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_out_last", bus.out_last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_mem_addr", bus.mem_addr, 0);
    chk("abort_out_data", bus.out_data, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_done", done, 0);
      chk("post_rst_no_valid", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    start_burst(0, 2, 1, k0);
    wait_done(k0 + 3, 20);

    // start while busy is ignored; start in the done cycle is taken
    @(posedge clk);
    #1;
    start_burst(0, 4, 1, k0);
    @(posedge clk);
    #1;
    start = 1'b1;
    base  = 4'd12;
    len   = 5'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(k0 + 5, 40);
    start_burst(2, 3, 1, k1);
    wait_done(k1 + 4, 40);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d cycles required completion", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gobou_img_fetch.md
GOBOU_IMG_FETCH -- requirements
Module: gobou_img_fetch

Interface
REQ-001 Parameters SHALL be taken from gobou.vh: DWIDTH (data word width) and IMGSIZE (image memory address width); no local override.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  one-cycle request to begin a fetch burst.
REQ-005 base  input  IMGSIZE  first word address, sampled with start.
REQ-006 len  input  IMGSIZE+1  word count 0..2^IMGSIZE, sampled with start.
REQ-007 mem_addr  output  IMGSIZE  read address to the image memory.
REQ-008 read_data  input  signed DWIDTH  image memory data, valid the cycle after the address was issued.
REQ-009 out_valid / out_ready  output / input  1  downstream handshake; a transfer occurs when both are high at a rising edge.
REQ-010 out_data  output  signed DWIDTH  fetched word.
REQ-011 out_last  output  1  high with the final word of a burst.
REQ-012 busy  output  1  high from the cycle after start is accepted until done.
REQ-013 done  output  1  one-cycle pulse on burst completion.

Function
REQ-014 States SHALL be IDLE, RUN and DRAIN: IDLE->RUN on start with len>0; RUN->DRAIN when the last address has issued; DRAIN->IDLE when the last word transfers.
REQ-015 In RUN the block SHALL issue one address per cycle while (words in flight + words buffered) < 2, incrementing mem_addr by 1 modulo 2^IMGSIZE.
REQ-016 Returned read_data SHALL be captured into a 2-entry FIFO in the cycle after issue; words SHALL leave in address order with no loss or duplication.
REQ-017 With out_ready held high, the first out_valid SHALL be 2 cycles after start is sampled and throughput SHALL be one word per cycle.
REQ-018 out_data and out_last SHALL remain stable while out_valid is high and out_ready is low.
REQ-019 done SHALL pulse in the cycle after the out_last transfer, and busy SHALL fall in that same cycle.
REQ-020 A start with len=0 SHALL issue no address, produce no out_valid, and pulse done in the next cycle.
REQ-021 A start while busy SHALL be ignored.
REQ-022 A start in the same cycle as done SHALL be accepted.
REQ-023 A burst crossing address 2^IMGSIZE-1 SHALL wrap to 0.
REQ-024 With len=2^IMGSIZE, every word SHALL be read exactly once.
REQ-025 mem_addr SHALL hold its last issued value when not issuing.
REQ-026 The block SHALL never drive memory writes.

Reset
REQ-027 While rst is high: state IDLE; FIFO empty; out_valid=0, out_last=0, busy=0, done=0, mem_addr=0, out_data=0.
REQ-028 rst asserted mid-burst SHALL abort the burst without a done pulse; discarded words SHALL not reappear after reset.

Configuration
REQ-029 Macro GOBOU_IMG_FETCH_STALL_CNT_EN defined: adds output stall_cnt (32 bits), cleared by rst and on each accepted start, incremented every cycle with out_valid=1 and out_ready=0, and saturating at all-ones.
REQ-030 Macro undefined: the stall_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Memory preloaded mem[i]=i; start with base=5, len=4, out_ready=1 -> out_data 5,6,7,8 on consecutive cycles starting 2 cycles after start; out_last only with 8; done one cycle later.
REQ-032 base=2^IMGSIZE-2, len=4 -> mem_addr sequence max-1, max, 0, 1; data in that order.
REQ-033 len=8, out_ready toggling 1,0,0,1 repeatedly -> all 8 words delivered in order, data stable during stalls; with the macro defined, stall_cnt equals the counted stalled-valid cycles.
REQ-034 len=0 -> done the next cycle; no out_valid at any point.
REQ-035 rst pulsed after 3 of 6 words transferred -> outputs return to reset values immediately; no done; a subsequent start with base=0, len=2 delivers 0,1 correctly.
REQ-036 start asserted during an active burst -> ignored; a start on the done cycle launches the new burst.
